// File: rtl/lru_pkg.sv
// Shared types and defaults for the LRU request pacer and the LRU buffer bench.
package lru_pkg;

    localparam int LRU_DATA_W = 8;
    localparam int LRU_DEPTH  = 4;
    localparam int LRU_GAP    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } pacer_state_t;

endpackage

// File: rtl/lru_fifo.sv
// Small synchronous FIFO with a combinational head; the caller guards push-when-full and pop-when-empty.
module lru_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/lru_req_pacer.sv
// Feeds the LRU buffer one word per GAP cycles from a small FIFO.
// Optional LRU_PACER_DEDUP_EN: drop a push that repeats the last accepted word.
module lru_req_pacer
    import lru_pkg::*;
#(
    parameter int DATA_W = LRU_DATA_W,
    parameter int DEPTH  = LRU_DEPTH,
    parameter int GAP    = LRU_GAP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       valid_data,
    output logic [DATA_W-1:0]          data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(GAP);

    pacer_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_data_q, valid_data_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              push_acc;
    logic              enq;
    logic              pop;

    assign in_ready = (fifo_count != CW'(DEPTH));
    assign push_acc = in_valid & in_ready;

`ifdef LRU_PACER_DEDUP_EN
    logic [DATA_W-1:0] last_val_q, last_val_d;
    logic              last_vld_q, last_vld_d;

    // A repeat of the MRU word is a no-op downstream, so it is handshaken but never queued.
    always_comb begin
        last_val_d = last_val_q;
        last_vld_d = last_vld_q;
        if (push_acc) begin
            last_val_d = in_data;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_val_q <= last_val_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign enq = push_acc & ~(last_vld_q & (in_data == last_val_q));
`else
    assign enq = push_acc;
`endif

    lru_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // ISSUE plus GAP-1 WAIT cycles (counter GAP-2 down to 0) spaces pulses exactly GAP apart.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_data_d = 1'b0;
        data_d       = data_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d      = ISSUE;
                    pop          = 1'b1;
                    valid_data_d = 1'b1;
                    data_d       = fifo_head;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(GAP - 2);
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (fifo_count != '0) begin
                    state_d      = ISSUE;
                    pop          = 1'b1;
                    valid_data_d = 1'b1;
                    data_d       = fifo_head;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_data_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_data_q <= valid_data_d;
            data_q       <= data_d;
        end
    end

    assign valid_data = valid_data_q;
    assign data       = data_q;
    assign count      = fifo_count;
    assign busy       = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_lru_req_pacer.sv
// Scoreboard bench for lru_req_pacer: a timing-level model predicts each pulse's word and edge.
module tb_lru_req_pacer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int GAP    = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              valid_data;
    logic [DATA_W-1:0] data;
    logic [$clog2(DEPTH):0] count;
    logic              busy;

    lru_req_pacer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .valid_data (valid_data),
        .data       (data),
        .count      (count),
        .busy       (busy)
    );

    typedef struct {
        logic [DATA_W-1:0] word;
        int                issue;
    } exp_t;

    exp_t              sb[$];
    int                cyc = 0;
    int                ncmp = 0;
    int                nerr = 0;
    logic [DATA_W-1:0] held = '0;
    bit                have_issue = 0;
    int                last_issue = 0;
    bit                last_acc_vld = 0;
    logic [DATA_W-1:0] last_acc_val = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: the value seen at a negedge is the number of the posedge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        foreach (sb[i]) if (sb[i].issue > cyc) n++;
        return n;
    endfunction

    // Monitor: every pulse must match the scoreboard head in both word and edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_data) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {24'b0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("pulse_data", {24'b0, data}, {24'b0, e.word});
                    checkOutput("pulse_edge", cyc, e.issue);
                    held = e.word;
                end
            end else begin
                if (sb.size() != 0 && sb[0].issue <= cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("missing_pulse", 0, {24'b0, e.word});
                end
                checkOutput("data_hold", {24'b0, data}, {24'b0, held});
            end
        end
    end

    // Called at a negedge; drives one edge worth of input and advances the model.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, output bit acc);
        int  mcnt;
        bit  ready_m;
        bit  busy_m;
        bit  drop;
        int  iss;
        in_valid = v;
        in_data  = d;
        #1;
        mcnt    = modelCount();
        ready_m = (mcnt != DEPTH);
        busy_m  = (mcnt != 0) || (have_issue && (cyc < last_issue + GAP));
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, ready_m});
        checkOutput("count", {29'b0, count}, mcnt);
        checkOutput("busy", {31'b0, busy}, {31'b0, busy_m});
        acc = v && ready_m;
        if (acc) begin
`ifdef LRU_PACER_DEDUP_EN
            drop = last_acc_vld && (d == last_acc_val);
`else
            drop = 0;
`endif
            last_acc_vld = 1;
            last_acc_val = d;
            if (!drop) begin
                iss = cyc + 2;
                if (have_issue && (last_issue + GAP > iss)) iss = last_issue + GAP;
                have_issue = 1;
                last_issue = iss;
                sb.push_back('{word: d, issue: iss});
            end
        end
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, acc);
    endtask

    // Asserts reset between edges and checks the outputs clear without waiting for a clock.
    task automatic applyReset();
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("rst_valid_data", {31'b0, valid_data}, 0);
        checkOutput("rst_data", {24'b0, data}, 0);
        checkOutput("rst_count", {29'b0, count}, 0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 1);
        checkOutput("rst_busy", {31'b0, busy}, 0);
        sb.delete();
        have_issue   = 0;
        held         = '0;
        last_acc_vld = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        logic [DATA_W-1:0] burst [5];
        burst[0] = 8'd4; burst[1] = 8'd5; burst[2] = 8'd1; burst[3] = 8'd2; burst[4] = 8'd3;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        applyReset();

        $display("[TB] single push into idle");
        applyStimulus(1'b1, 8'd4, acc);
        idleCycles(GAP + 4);

        $display("[TB] back-to-back burst");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, burst[i], acc);
        idleCycles(5 * GAP + 4);

        $display("[TB] full FIFO with held word");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h10 + 8'(i), acc);
        acc = 0;
        for (int k = 0; k < 100 && !acc; k++) applyStimulus(1'b1, 8'd7, acc);
        checkOutput("hold_accept", {31'b0, acc}, 1);
        idleCycles(6 * GAP + 4);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 8'hA1, acc);
        applyStimulus(1'b1, 8'hB2, acc);
        idleCycles(5);
        applyReset();
        idleCycles(3 * GAP);

        $display("[TB] repeated word");
        applyStimulus(1'b1, 8'd5, acc);
        applyStimulus(1'b1, 8'd5, acc);
        applyStimulus(1'b1, 8'd3, acc);
        idleCycles(4 * GAP);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic [DATA_W-1:0] d;
            v = ($urandom_range(0, 99) < 45);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(4, 6));
            applyStimulus(v, d, acc);
        end
        idleCycles((DEPTH + 2) * GAP + 8);
        checkOutput("drain_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
